// File: rtl/halfwave_pwm.sv
// Halfwave-to-H-bridge PWM output stage: double-buffered samples, 256-cycle period, optional reversal dead time.
// Optional feature: define HALFWAVE_PWM_DEADTIME_EN to insert DEAD cycles of dead time on a polarity reversal.
module halfwave_pwm #(
  parameter int unsigned DEAD = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_stb,
  input  logic [7:0] pos_in,
  input  logic [7:0] neg_in,
  output logic       pwm_p,
  output logic       pwm_n,
  output logic       period_stb,
  output logic       err_both
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE_P = 3'd1,
    DRIVE_N = 3'd2
`ifdef HALFWAVE_PWM_DEADTIME_EN
    ,
    DEAD_P  = 3'd3,
    DEAD_N  = 3'd4
`endif
  } state_t;

  typedef enum logic [1:0] {
    SIDE_IDLE = 2'd0,
    SIDE_P    = 2'd1,
    SIDE_N    = 2'd2
  } side_t;

`ifdef HALFWAVE_PWM_DEADTIME_EN
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic          DEAD_ON   = (DEAD != 0);
`else
  logic [CW-1:0] dead_unused;
  assign dead_unused = CW'(DEAD);
`endif

  logic [CW-1:0] cnt;
  logic [CW-1:0] pend_pos, pend_neg;
  logic          pend_vld;
  logic [CW-1:0] act_pos, act_neg;
  logic [CW-1:0] duty;
  state_t        state, state_nxt;

  logic          wrap_c;
  logic [CW-1:0] new_pos_c, new_neg_c, new_duty_c;
  side_t         new_side_c;
  logic          new_both_c;
  logic          pwm_p_nxt, pwm_n_nxt, period_stb_nxt, err_both_nxt;

  assign wrap_c = (cnt == CNT_LAST);

  // Sample applied at the wrap: a strobe on the wrap cycle bypasses pending, then pending, else hold.
  always_comb begin
    new_pos_c = act_pos;
    new_neg_c = act_neg;
    if (sample_stb) begin
      new_pos_c = pos_in;
      new_neg_c = neg_in;
    end else if (pend_vld) begin
      new_pos_c = pend_pos;
      new_neg_c = pend_neg;
    end
  end

  // Side decode; P wins when both magnitudes are non-zero.
  always_comb begin
    new_side_c = SIDE_IDLE;
    new_duty_c = '0;
    new_both_c = (new_pos_c != '0) && (new_neg_c != '0);
    if (new_pos_c != '0) begin
      new_side_c = SIDE_P;
      new_duty_c = new_pos_c;
    end else if (new_neg_c != '0) begin
      new_side_c = SIDE_N;
      new_duty_c = new_neg_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_pos <= '0;
      pend_neg <= '0;
      pend_vld <= 1'b0;
      act_pos  <= '0;
      act_neg  <= '0;
      duty     <= '0;
    end else if (wrap_c) begin
      act_pos  <= new_pos_c;
      act_neg  <= new_neg_c;
      duty     <= new_duty_c;
      pend_vld <= 1'b0;
    end else if (sample_stb) begin
      pend_pos <= pos_in;
      pend_neg <= neg_in;
      pend_vld <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: side selection at the wrap, dead-time exit mid-period
  always_comb begin
    state_nxt = state;
    if (wrap_c) begin
      case (new_side_c)
        SIDE_P: begin
          state_nxt = DRIVE_P;
`ifdef HALFWAVE_PWM_DEADTIME_EN
          if (DEAD_ON && (state == DRIVE_N || state == DEAD_N)) state_nxt = DEAD_P;
`endif
        end
        SIDE_N: begin
          state_nxt = DRIVE_N;
`ifdef HALFWAVE_PWM_DEADTIME_EN
          if (DEAD_ON && (state == DRIVE_P || state == DEAD_P)) state_nxt = DEAD_N;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
`ifdef HALFWAVE_PWM_DEADTIME_EN
    else if (cnt == DEAD_LAST) begin
      if (state == DEAD_P) state_nxt = DRIVE_P;
      if (state == DEAD_N) state_nxt = DRIVE_N;
    end
`endif
  end

  // Output next values; only one DRIVE state can be active, so the pins are exclusive.
  always_comb begin
    pwm_p_nxt      = (state == DRIVE_P) && (cnt < duty);
    pwm_n_nxt      = (state == DRIVE_N) && (cnt < duty);
    period_stb_nxt = wrap_c;
    err_both_nxt   = err_both || (wrap_c && new_both_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_p      <= 1'b0;
      pwm_n      <= 1'b0;
      period_stb <= 1'b0;
      err_both   <= 1'b0;
    end else begin
      pwm_p      <= pwm_p_nxt;
      pwm_n      <= pwm_n_nxt;
      period_stb <= period_stb_nxt;
      err_both   <= err_both_nxt;
    end
  end

endmodule
